// File: rtl/silife_pkg.sv
// Shared types and sizing helpers for the silife serial load path.
package silife_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD
    } load_state_t;

    // Number of input words needed to cover one frame.
    function automatic int unsigned nwords(input int unsigned frame_bits,
                                           input int unsigned word_width);
        return (frame_bits + word_width - 1) / word_width;
    endfunction

    // Bits taken from the MSBs of the final word of a frame.
    function automatic int unsigned last_word_bits(input int unsigned frame_bits,
                                                   input int unsigned word_width);
        return frame_bits - word_width * (nwords(frame_bits, word_width) - 1);
    endfunction

endpackage

// File: rtl/silife_load_shifter.sv
// One-entry word buffer feeding an MSB-first shift register with a bit counter.
module silife_load_shifter #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned LAST_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] i_word,
    input  logic                  i_word_valid,
    input  logic                  i_accept_en,
    output logic                  o_word_ready,
    input  logic                  i_is_last,
    input  logic                  i_shift,
    input  logic                  i_flush,
    output logic                  o_buf_v,
    output logic                  o_msb,
    output logic                  o_empty
);
    localparam int unsigned CW = $clog2(WORD_WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WORD_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(LAST_BITS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WORD_WIDTH-1:0] r_buf;
    logic                  r_buf_last;
    logic                  r_buf_v;
    logic [WORD_WIDTH-1:0] r_sr;
    logic [CW-1:0]         r_cnt;

    logic w_empty;
    logic w_accept;
    logic w_load;

    assign w_empty      = (r_cnt == '0);
    assign o_word_ready = !r_buf_v && i_accept_en;
    assign w_accept     = i_word_valid && o_word_ready;
    // Reload on the shift that consumes the final bit so word boundaries cost no cycles.
    assign w_load       = r_buf_v && (w_empty || (i_shift && (r_cnt == CNT_ONE)));

    assign o_buf_v = r_buf_v;
    assign o_empty = w_empty;
    assign o_msb   = r_sr[WORD_WIDTH-1] && !w_empty;

    // Buffer fill/drain and shift register load/shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buf      <= '0;
            r_buf_last <= 1'b0;
            r_buf_v    <= 1'b0;
            r_sr       <= '0;
            r_cnt      <= '0;
        end else if (i_flush) begin
            r_buf_v    <= 1'b0;
            r_buf_last <= 1'b0;
            r_sr       <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_accept) begin
                r_buf      <= i_word;
                r_buf_last <= i_is_last;
                r_buf_v    <= 1'b1;
            end else if (w_load) begin
                r_buf_v <= 1'b0;
            end
            if (w_load) begin
                r_sr  <= r_buf;
                r_cnt <= r_buf_last ? CNT_LAST : CNT_FULL;
            end else if (i_shift && !w_empty) begin
                r_sr  <= {r_sr[WORD_WIDTH-2:0], 1'b0};
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/silife_load_ctrl.sv
// Serializes configuration words onto the silife grid load chain (cs/clk/data).
module silife_load_ctrl
    import silife_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned FRAME_BITS = 128,
    parameter int unsigned CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] i_word,
    input  logic                  i_word_valid,
    output logic                  o_word_ready,
    input  logic                  i_abort,
    input  logic                  i_grid_busy,
    output logic                  o_load_cs,
    output logic                  o_load_clk,
    output logic                  o_load_data,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int unsigned NWORDS    = nwords(FRAME_BITS, WORD_WIDTH);
    localparam int unsigned LAST_BITS = last_word_bits(FRAME_BITS, WORD_WIDTH);
    localparam int unsigned FCW       = $clog2(FRAME_BITS + 1);
    localparam int unsigned DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned WCW       = $clog2(NWORDS + 1);

    localparam logic [DW-1:0]  DIV_MAX   = DW'(CLK_DIV - 1);
    localparam logic [FCW-1:0] FRAME_END = FCW'(FRAME_BITS);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(NWORDS - 1);
    localparam logic [WCW-1:0] WORD_MAX  = WCW'(NWORDS);

    load_state_t    r_state, w_state_d;
    logic [DW-1:0]  r_div_cnt, w_div_d;
    logic [FCW-1:0] r_frame_cnt, w_frame_d;
    logic [WCW-1:0] r_word_cnt, w_word_cnt_d;
    logic           r_done, w_done_d;

    logic w_accept_en;
    logic w_accept;
    logic w_phase_end;
    logic w_shift;
    logic w_buf_v;
    logic w_msb;
    logic w_empty;
    logic w_is_last;

    // Busy only gates a new frame; words beyond the frame wait for IDLE.
    assign w_accept_en = ((r_state != IDLE) || !i_grid_busy) && !i_abort &&
                         (r_word_cnt < WORD_MAX);
    assign w_accept    = i_word_valid && o_word_ready;
    assign w_phase_end = (r_div_cnt == DIV_MAX);
    assign w_is_last   = (r_word_cnt == WORD_LAST);

    silife_load_shifter #(
        .WORD_WIDTH (WORD_WIDTH),
        .LAST_BITS  (LAST_BITS)
    ) u_shifter (
        .clk          (clk),
        .reset        (reset),
        .i_word       (i_word),
        .i_word_valid (i_word_valid),
        .i_accept_en  (w_accept_en),
        .o_word_ready (o_word_ready),
        .i_is_last    (w_is_last),
        .i_shift      (w_shift),
        .i_flush      (i_abort),
        .o_buf_v      (w_buf_v),
        .o_msb        (w_msb),
        .o_empty      (w_empty)
    );

    assign o_load_cs   = (r_state != IDLE);
    assign o_load_clk  = (r_state == HIGH);
    assign o_load_data = ((r_state == LOW) || (r_state == HIGH)) && w_msb;
    assign o_busy      = (r_state != IDLE);
    assign o_done      = r_done;

    // Next-state, phase divider, frame and word counters.
    always_comb begin
        w_state_d    = r_state;
        w_div_d      = r_div_cnt;
        w_frame_d    = r_frame_cnt;
        w_word_cnt_d = r_word_cnt;
        w_done_d     = 1'b0;
        w_shift      = 1'b0;

        if (w_accept) begin
            w_word_cnt_d = r_word_cnt + WCW'(1);
        end

        if (i_abort) begin
            w_state_d    = IDLE;
            w_div_d      = '0;
            w_frame_d    = '0;
            w_word_cnt_d = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_div_d   = '0;
                    w_frame_d = '0;
                    if (w_buf_v) begin
                        w_state_d = SETUP;
                    end
                end
                SETUP: begin
                    if (w_phase_end) begin
                        w_state_d = LOW;
                        w_div_d   = '0;
                    end else begin
                        w_div_d = r_div_cnt + DW'(1);
                    end
                end
                LOW: begin
                    // Underflow: hold the low phase with the divider frozen.
                    if (!w_empty) begin
                        if (w_phase_end) begin
                            w_state_d = HIGH;
                            w_div_d   = '0;
                        end else begin
                            w_div_d = r_div_cnt + DW'(1);
                        end
                    end
                end
                HIGH: begin
                    if (w_phase_end) begin
                        w_shift   = 1'b1;
                        w_frame_d = r_frame_cnt + FCW'(1);
                        w_div_d   = '0;
                        w_state_d = ((r_frame_cnt + FCW'(1)) == FRAME_END) ? HOLD : LOW;
                    end else begin
                        w_div_d = r_div_cnt + DW'(1);
                    end
                end
                HOLD: begin
                    if (w_phase_end) begin
                        w_state_d    = IDLE;
                        w_div_d      = '0;
                        w_word_cnt_d = '0;
                        w_done_d     = 1'b1;
                    end else begin
                        w_div_d = r_div_cnt + DW'(1);
                    end
                end
                default: begin
                    w_state_d = IDLE;
                    w_div_d   = '0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_div_cnt   <= '0;
            r_frame_cnt <= '0;
            r_word_cnt  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_div_cnt   <= w_div_d;
            r_frame_cnt <= w_frame_d;
            r_word_cnt  <= w_word_cnt_d;
            r_done      <= w_done_d;
        end
    end

endmodule

// File: doc/silife_load_ctrl.md
Name: silife_load_ctrl

Overview:
Upstream feeder for the silife tile grid's serial load chain. Accepts configuration words over a valid/ready stream and serializes them MSB-first onto the grid's shared load chip-select, load clock and load data lines. Loads are held off while the grid reports busy, so a new pattern never lands mid-generation. One frame covers the whole daisy-chained grid.

Parameters:
WORD_WIDTH, 32, width of the input word.
FRAME_BITS, 128, total bits shifted per frame; the default suits 2 tiles of 8x8 cells.
CLK_DIV, 2, number of clk cycles per load-clock phase (low or high); minimum 1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
i_word  in  WORD_WIDTH  input word; bit WORD_WIDTH-1 is shifted first
i_word_valid  in  1  input word valid
o_word_ready  out  1  word accepted on any cycle where valid and ready are both high
i_abort  in  1  synchronous abort of the current frame
i_grid_busy  in  1  busy signal from the grid; high means a generation is in progress
o_load_cs  out  1  load chip-select to the grid; active-high for the whole frame
o_load_clk  out  1  load clock to the grid; the grid samples data on the rising edge
o_load_data  out  1  serial load data to the grid
o_busy  out  1  high whenever the state is not IDLE
o_done  out  1  one-cycle pulse when a frame completes normally

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; o_load_cs, o_load_clk, o_load_data, o_done and o_busy are all 0; word buffer empty; all counters 0. A reset asserted mid-frame drops o_load_cs immediately, with no done pulse.
- Datapath: 1-entry word buffer (buf, buf_v) feeding the shift register sr, which holds the current word and its remaining bit count.
- o_word_ready = !buf_v && (state != IDLE || !i_grid_busy) && !i_abort.
- A word is accepted when i_word_valid && o_word_ready; it sets buf_v.
- Word loads into sr when sr is empty and buf_v=1; buf_v clears in the same cycle.
- Bits per word: WORD_WIDTH, except the last word of a frame, which supplies FRAME_BITS - WORD_WIDTH*(NWORDS-1) bits, taken from its MSBs.
- NWORDS = ceil(FRAME_BITS/WORD_WIDTH). Unused LSBs of the last word are ignored.
- FSM states:
  - IDLE: when buf_v=1 -> SETUP, setting o_load_cs=1.
  - SETUP: cs high, clk low for CLK_DIV cycles, then -> LOW.
  - LOW: o_load_data = sr MSB, o_load_clk=0, for CLK_DIV cycles, then -> HIGH.
  - LOW underflow: if sr is empty on entry (no word available), stall in LOW with the divider frozen; cs stays 1.
  - HIGH: o_load_clk=1 for CLK_DIV cycles. On exit: shift sr, decrement the bits-remaining count, increment frame_cnt.
  - HIGH exit branch: if frame_cnt==FRAME_BITS -> HOLD; else -> LOW.
  - HOLD: cs high, clk low for CLK_DIV cycles, then cs=0, o_done=1 for one cycle -> IDLE.
- o_load_data changes only while o_load_clk is low; it is stable for CLK_DIV cycles before each rising edge. o_load_data=0 whenever cs=0.
- Frame length, no stalls: (2*FRAME_BITS + 2)*CLK_DIV cycles from SETUP entry to the o_done pulse.
- Counters:
  - frame_cnt is $clog2(FRAME_BITS+1) bits wide; no wrap within a frame.
  - div_cnt is max(1,$clog2(CLK_DIV)) bits wide; it counts 0..CLK_DIV-1 and reloads to 0 on each phase change.
- Any word arriving beyond NWORDS in a frame is not accepted until IDLE. It then starts the next frame, subject to i_grid_busy.
- i_grid_busy is sampled only in IDLE; once SETUP is entered, the frame completes regardless of busy.
- i_abort (any state): next cycle -> IDLE; cs, clk and data go to 0; buffer and sr flushed; no o_done. Abort wins over a simultaneous word accept; the word is not accepted.

Decomposition:
- Package silife_pkg holds:
  - load_state_t enum: IDLE, SETUP, LOW, HIGH, HOLD.
  - localparam helper function nwords(FRAME_BITS, WORD_WIDTH).
  - last-word-bits helper.
- One sub-module, silife_load_shifter: owns buf, sr and the bits-remaining counter. Interface: word in, valid/ready, shift strobe, is_last_word, MSB out, empty.
- The FSM, divider and frame counter stay in silife_load_ctrl.

Test Plan:
1. Basic frame (defaults, CLK_DIV=2): 4 back-to-back words 0xA5000001, 0, 0, 0x80000000 -> 128 rising edges of o_load_clk.
   - Sampled bits are 1,0,1,0,0,1,0,1,... and the final bit is 0.
   - o_done pulses 516 cycles after SETUP entry; cs is low both before and after the frame.
2. Partial last word (FRAME_BITS=40): words 0xFFFFFFFF, 0xC3FFFFFF -> exactly 40 clock edges; last 8 bits are 11000011; o_done pulses once.
3. Underflow stall: second word is delayed 50 cycles.
   - o_load_clk holds 0 and cs holds 1 through the gap; no extra edges.
   - Bit sequence is intact; frame length is +50 cycles.
4. Grid busy: i_grid_busy=1 with a word valid in IDLE -> o_word_ready=0 and cs stays 0. Deasserting busy lets the word be accepted the next cycle and enter SETUP.
5. Abort and reset: i_abort after 10 bits -> cs, clk and data go to 0 the next cycle, o_done never pulses, buffer flushed. A fresh frame then runs cleanly.
   - Repeat with reset=0 mid-HIGH -> all outputs 0 immediately (asynchronous).
6. CLK_DIV=1 corner: each load-clock phase lasts 1 cycle; total frame (2*128+2)*1 = 258 cycles; data is stable for 1 cycle before each rising edge.
